l2_forward_stage: RTL and testbench
===================================

# l2_forward_stage

Downstream neighbour of the parser. Consumes the parser's metadata-plus-packet stream and performs L2 learning and destination-MAC lookup in a small fully associative MAC table. It writes a forwarding port bitmap into the last metadata word and forwards every word with a fixed latency of one cycle. Packets are processed one at a time; `ready_out` backpressures the parser at packet boundaries.

## Interface
- `NUM_ENTRIES`, 16: number of MAC table entries, 2..64.
- `NUM_PORTS`, 8: number of physical ports, 1..16. Sets the width of the meaningful bitmap bits.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-low.
- `metadata_in_valid` input 1: input word valid.
- `metadata_in` input 134: input word. [133:132] is the tag, [127:0] is the payload.
- `ready_out` output 1: this stage accepts a new metadata head. Drives the parser's `ready_in`.
- `metadata_out_valid` output 1: output word valid.
- `metadata_out` output 134: output word.
- `ready_in` input 1: downstream accepts a new packet head. Checked only at the head.
- `hit_cnt` output 32: count of dmac lookup hits, wrapping.
- `flood_cnt` output 32: count of packets flooded (miss, broadcast or multicast), wrapping.
- `err_cnt` output 16: count of malformed sequences, saturating at 16'hFFFF.

## Operation
- **Stream format:**
  - Metadata consists of M0 (tag 01), M1 (tag 11) and M2 (tag 00).
  - The packet follows: head (tag 01), body (tag 11), tail (tag 10).
  - Words with `metadata_in_valid` low are ignored in every state and do not advance the FSM.
- **Fields:**
  - M1[127:80] = dmac.
  - M1[79:32] = smac.
  - M1[3:0] = ingress port.
  - M2[15:0] is replaced by the forwarding bitmap. All other bits of every word pass through unchanged.
- **FSM states:** IDLE, WAIT_M1, WAIT_M2, WAIT_HEAD, PKT, SKIP.
  - **IDLE:** accepts a valid tag-01 word only when `ready_out`=1. Then go to WAIT_M1.
  - **WAIT_M1:** a tag-11 word performs the lookup and learning, then go to WAIT_M2.
  - **WAIT_M2:** a tag-00 word is forwarded with the bitmap inserted, then go to WAIT_HEAD.
  - **WAIT_HEAD:** a tag-01 word goes to PKT.
  - **PKT:** a tag-10 word goes to IDLE.
  - **Any unexpected tag:** `err_cnt`+1, the word is forwarded unmodified, go to SKIP. SKIP forwards words until a tag-10 word, then returns to IDLE.
- **Lookup:**
  - Compare dmac against all valid entries. If several match, the lowest index wins.
  - Hit: bitmap = 1<<entry_port and `hit_cnt`+1.
  - dmac[40]=1 (broadcast or multicast) or miss: flood. Bitmap = ((1<<NUM_PORTS)-1) & ~(1<<ingress) and `flood_cnt`+1.
  - If ingress ≥ NUM_PORTS, flood to all NUM_PORTS ports.
  - A bitmap of 0 is possible when NUM_PORTS=1; it is forwarded as is.
- **Learning:**
  - Learning happens in the same cycle as the lookup. The lookup sees the table before the update, so smac==dmac misses on first sight.
  - Learning is skipped when smac[40]=1, smac=0, or ingress ≥ NUM_PORTS.
  - smac hit: overwrite that entry's port.
  - smac miss: write {valid, smac, port} at the replacement pointer, then advance the pointer. The pointer wraps from NUM_ENTRIES-1 to 0 and overwrites when the table is full.
- **`ready_out`:**
  - Reset value is 1.
  - Cleared in the cycle after the M0 head is accepted.
  - Re-set to `ready_in` in the cycle after the tail word is accepted or SKIP terminates.
  - In IDLE it follows `ready_in` with one cycle of register delay.
- **Reset values:** all outputs 0, except `ready_out`=1. All table entries invalid, replacement pointer 0, FSM in IDLE. Reset mid-packet discards the packet; the remainder is not forwarded (FSM in IDLE ignores non-01 words).

## Timing
- Latency is exactly 1 cycle: `metadata_out`/`metadata_out_valid` at cycle n+1 correspond to the input at cycle n.
- The bitmap is registered at the M1 cycle and inserted at the M2 cycle. M2 may follow M1 back-to-back.
- Table writes become visible to the lookup of the next packet. The minimum packet gap is 0 cycles after `ready_out` returns.
- Counters update in the cycle after the M1 word.

## Test plan
- **Learning then hit:** pkt A with smac=00:11:22:33:44:55, ingress 2, unknown dmac, gives M2[15:0]=16'h00FB and `flood_cnt`=1. Then pkt B with dmac=00:11:22:33:44:55, ingress 5, gives M2[15:0]=16'h0004 and `hit_cnt`=1.
- **Broadcast:** dmac=FF:FF:FF:FF:FF:FF, ingress 0 gives bitmap 16'h00FE. No learning of dmac; smac is learned.
- **Table wrap:** 17 distinct smacs with NUM_ENTRIES=16. The 17th overwrites entry 0; lookup of the first smac then floods.
- **Malformed stream:** M0 followed by a tag-10 word gives `err_cnt`=1, the word is forwarded unchanged, and `ready_out` returns to 1 one cycle later. The next well-formed packet processes normally.
- **Gaps and backpressure:**
  - Valid low between words leaves the output identical, delayed by 1 cycle.
  - `ready_in`=0 in IDLE drives `ready_out`=0 after 1 cycle; a held-off head is not accepted.
- **Async reset during PKT:** all outputs return to their reset values immediately, the table is invalidated, and subsequent body words produce no output.

Source files
------------

// File: rtl/l2_forward_stage.sv
// L2 learning / dmac lookup stage with a fully associative MAC table.
// Ports: clk, reset(async low); metadata_in(_valid) in; metadata_out(_valid) out;
//   ready_out to parser, ready_in from downstream; hit/flood/err counters.
module l2_forward_stage #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_PORTS   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         metadata_in_valid,
  input  logic [133:0] metadata_in,
  output logic         ready_out,
  output logic         metadata_out_valid,
  output logic [133:0] metadata_out,
  input  logic         ready_in,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  flood_cnt,
  output logic [15:0]  err_cnt
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [16:0] ALL17 = (17'd1 << NUM_PORTS) - 17'd1;
  localparam logic [15:0] ALL = ALL17[15:0];
  localparam logic [4:0] NP = 5'(NUM_PORTS);
  localparam logic [IW-1:0] LAST = IW'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_M1,
    WAIT_M2,
    WAIT_HEAD,
    PKT,
    SKIP
  } state_t;

  state_t state;
  state_t nxt;

  logic [1:0]  tag;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [3:0]  ingress;

  assign tag     = metadata_in[133:132];
  assign dmac    = metadata_in[127:80];
  assign smac    = metadata_in[79:32];
  assign ingress = metadata_in[3:0];

  logic          tbl_vld  [NUM_ENTRIES];
  logic [47:0]   tbl_mac  [NUM_ENTRIES];
  logic [3:0]    tbl_port [NUM_ENTRIES];
  logic [IW-1:0] ptr;

  logic          d_hit;
  logic [IW-1:0] d_idx;
  logic          s_hit;
  logic [IW-1:0] s_idx;

  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    d_hit = 1'b0;
    d_idx = '0;
    s_hit = 1'b0;
    s_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (tbl_vld[i] && tbl_mac[i] == dmac) begin
        d_hit = 1'b1;
        d_idx = IW'(i);
      end
      if (tbl_vld[i] && tbl_mac[i] == smac) begin
        s_hit = 1'b1;
        s_idx = IW'(i);
      end
    end
  end

  logic        in_rng;
  logic        fwd_hit;
  logic [15:0] flood_bm;
  logic [15:0] hit_bm;
  logic [15:0] bm_q;

  assign in_rng   = {1'b0, ingress} < NP;
  assign fwd_hit  = d_hit && !dmac[40];
  assign flood_bm = in_rng ? (ALL & ~(16'd1 << ingress)) : ALL;
  assign hit_bm   = 16'd1 << tbl_port[d_idx];

  logic fwd;
  logic err;
  logic lookup;
  logic ins;
  logic head_acc;
  logic pkt_done;
  logic learn;

  always_comb begin
    nxt      = state;
    fwd      = 1'b0;
    err      = 1'b0;
    lookup   = 1'b0;
    ins      = 1'b0;
    head_acc = 1'b0;
    pkt_done = 1'b0;
    if (metadata_in_valid) begin
      unique case (state)
        IDLE: begin
          if (tag == 2'b01 && ready_out) begin
            fwd      = 1'b1;
            head_acc = 1'b1;
            nxt      = WAIT_M1;
          end
        end
        WAIT_M1: begin
          fwd = 1'b1;
          if (tag == 2'b11) begin
            lookup = 1'b1;
            nxt    = WAIT_M2;
          end else begin
            err = 1'b1;
          end
        end
        WAIT_M2: begin
          fwd = 1'b1;
          if (tag == 2'b00) begin
            ins = 1'b1;
            nxt = WAIT_HEAD;
          end else begin
            err = 1'b1;
          end
        end
        WAIT_HEAD: begin
          fwd = 1'b1;
          if (tag == 2'b01) nxt = PKT;
          else err = 1'b1;
        end
        PKT: begin
          fwd = 1'b1;
          if (tag == 2'b10) begin
            pkt_done = 1'b1;
            nxt      = IDLE;
          end else if (tag != 2'b11) begin
            err = 1'b1;
          end
        end
        SKIP: begin
          fwd = 1'b1;
          if (tag == 2'b10) begin
            pkt_done = 1'b1;
            nxt      = IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
      // An unexpected tail already ends the packet, so no SKIP needed.
      if (err) begin
        if (tag == 2'b10) begin
          pkt_done = 1'b1;
          nxt      = IDLE;
        end else begin
          nxt = SKIP;
        end
      end
    end
  end

  assign learn = lookup && !smac[40] && (smac != 48'd0) && in_rng;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_out <= 1'b1;
    end else if (head_acc) begin
      ready_out <= 1'b0;
    end else if (pkt_done || state == IDLE) begin
      ready_out <= ready_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      metadata_out_valid <= 1'b0;
      metadata_out       <= '0;
    end else begin
      metadata_out_valid <= fwd;
      if (fwd) begin
        metadata_out <= ins ? {metadata_in[133:16], bm_q}
                            : metadata_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bm_q      <= '0;
      hit_cnt   <= '0;
      flood_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (lookup) begin
        bm_q <= fwd_hit ? hit_bm : flood_bm;
        if (fwd_hit) hit_cnt <= hit_cnt + 32'd1;
        else flood_cnt <= flood_cnt + 32'd1;
      end
      if (err && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_vld[i]  <= 1'b0;
        tbl_mac[i]  <= '0;
        tbl_port[i] <= '0;
      end
    end else if (learn) begin
      if (s_hit) begin
        tbl_port[s_idx] <= ingress;
      end else begin
        tbl_vld[ptr]  <= 1'b1;
        tbl_mac[ptr]  <= smac;
        tbl_port[ptr] <= ingress;
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_forward_stage.sv
// Testbench for l2_forward_stage: directed packets against a
// spec-level scoreboard model plus literal bitmap/counter checks.
module tb_l2_forward_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         metadata_in_valid = 1'b0;
  logic [133:0] metadata_in = '0;
  logic         ready_out;
  logic         metadata_out_valid;
  logic [133:0] metadata_out;
  logic         ready_in = 1'b1;
  logic [31:0]  hit_cnt;
  logic [31:0]  flood_cnt;
  logic [15:0]  err_cnt;

  l2_forward_stage #(.NUM_ENTRIES(16), .NUM_PORTS(8)) dut (
    .clk(clk),
    .reset(reset),
    .metadata_in_valid(metadata_in_valid),
    .metadata_in(metadata_in),
    .ready_out(ready_out),
    .metadata_out_valid(metadata_out_valid),
    .metadata_out(metadata_out),
    .ready_in(ready_in),
    .hit_cnt(hit_cnt),
    .flood_cnt(flood_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [133:0] act,
                       input logic [133:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- model ----------------
  localparam int P_IDLE = 0, P_M1 = 1, P_M2 = 2;
  localparam int P_HEAD = 3, P_PKT = 4, P_SKIP = 5;

  int           ph;
  logic         m_vld  [16];
  logic [47:0]  m_mac  [16];
  logic [3:0]   m_port [16];
  int           m_ptr;
  logic [15:0]  m_bm;

  logic         ex_valid, nx_valid;
  logic [133:0] ex_data, nx_data;
  logic         ex_ready, nx_ready;
  logic [31:0]  ex_hit, nx_hit, ex_flood, nx_flood;
  logic [15:0]  ex_err, nx_err;

  task automatic model_reset();
    ph = P_IDLE;
    m_ptr = 0;
    m_bm = '0;
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 0;
      m_mac[i] = '0;
      m_port[i] = '0;
    end
    ex_valid = 0; ex_data = '0; ex_ready = 1;
    ex_hit = 0; ex_flood = 0; ex_err = 0;
  endtask

  function automatic logic [1:0] want(input int p);
    case (p)
      P_M1:    return 2'b11;
      P_M2:    return 2'b00;
      P_HEAD:  return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_lookup();
    logic [47:0] dm, sm;
    logic [3:0] ing;
    int hi, si;
    dm = metadata_in[127:80];
    sm = metadata_in[79:32];
    ing = metadata_in[3:0];
    hi = -1;
    si = -1;
    for (int i = 0; i < 16; i++) begin
      if (hi < 0 && m_vld[i] && m_mac[i] == dm) hi = i;
      if (si < 0 && m_vld[i] && m_mac[i] == sm) si = i;
    end
    if (!dm[40] && hi >= 0) begin
      m_bm = 16'd1 << m_port[hi];
      nx_hit = nx_hit + 1;
    end else begin
      m_bm = (ing < 8) ? (16'h00FF & ~(16'd1 << ing)) : 16'h00FF;
      nx_flood = nx_flood + 1;
    end
    if (!sm[40] && sm != 0 && ing < 8) begin
      if (si >= 0) begin
        m_port[si] = ing;
      end else begin
        m_vld[m_ptr] = 1;
        m_mac[m_ptr] = sm;
        m_port[m_ptr] = ing;
        m_ptr = (m_ptr + 1) % 16;
      end
    end
  endtask

  task automatic model_step();
    logic [1:0] t;
    bit start_idle, took;
    t = metadata_in[133:132];
    start_idle = (ph == P_IDLE);
    took = 0;
    nx_valid = 0; nx_data = ex_data; nx_ready = ex_ready;
    nx_hit = ex_hit; nx_flood = ex_flood; nx_err = ex_err;
    if (metadata_in_valid) begin
      if (ph == P_IDLE) begin
        if (t == 2'b01 && ex_ready) begin
          took = 1; nx_valid = 1; nx_data = metadata_in;
          nx_ready = 0; ph = P_M1;
        end
      end else begin
        nx_valid = 1;
        nx_data = metadata_in;
        if (ph == P_SKIP || (ph == P_PKT && t == 2'b10)) begin
          if (t == 2'b10) begin ph = P_IDLE; nx_ready = ready_in; end
        end else if (t == want(ph)) begin
          if (ph == P_M1) begin model_lookup(); ph = P_M2; end
          else if (ph == P_M2) begin nx_data[15:0] = m_bm; ph = P_HEAD; end
          else if (ph == P_HEAD) ph = P_PKT;
        end else begin
          if (nx_err != 16'hFFFF) nx_err = nx_err + 1;
          if (t == 2'b10) begin ph = P_IDLE; nx_ready = ready_in; end
          else ph = P_SKIP;
        end
      end
    end
    if (start_idle && !took) nx_ready = ready_in;
  endtask

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("out_valid", metadata_out_valid, ex_valid);
      if (ex_valid) check("out_data", metadata_out, ex_data);
      check("ready_out", ready_out, ex_ready);
      check("hit_cnt", hit_cnt, ex_hit);
      check("flood_cnt", flood_cnt, ex_flood);
      check("err_cnt", err_cnt, ex_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [133:0] w, input logic ri);
    metadata_in_valid = v;
    metadata_in = w;
    ready_in = ri;
    model_step();
    @(posedge clk);
    ex_valid = nx_valid; ex_data = nx_data; ex_ready = nx_ready;
    ex_hit = nx_hit; ex_flood = nx_flood; ex_err = nx_err;
    @(negedge clk);
  endtask

  function automatic logic [133:0] mk(input logic [1:0] t, input logic [127:0] p);
    return {t, 4'h5, p};
  endfunction

  function automatic logic [133:0] w_m1(input logic [47:0] dm, input logic [47:0] sm,
                                        input logic [3:0] ing);
    return mk(2'b11, {dm, sm, 28'hABCDEF0, ing});
  endfunction

  logic [133:0] W_M0, W_M2, W_HD, W_TL;
  initial begin
    W_M0 = mk(2'b01, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    W_M2 = mk(2'b00, {112'hFEED_FACE_CAFE_BEEF_1234_5678_9ABC, 16'hABCD});
    W_HD = mk(2'b01, 128'h4EAD_0000_1111_2222_3333_4444_5555_6666);
    W_TL = mk(2'b10, 128'h7A11);
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_out && n < 20) begin
      step(0, '0, 1);
      n++;
    end
    check("ready_wait", ready_out, 1);
  endtask

  task automatic put(input logic [133:0] w, input int gap);
    step(1, w, 1);
    for (int g = 0; g < gap; g++) step(0, w, 1);
  endtask

  task automatic send_pkt(input logic [47:0] dm, input logic [47:0] sm,
                          input logic [3:0] ing, input int nb, input int gap,
                          output logic [15:0] bm);
    wait_ready();
    put(W_M0, gap);
    put(w_m1(dm, sm, ing), gap);
    step(1, W_M2, 1);
    bm = metadata_out[15:0];
    for (int g = 0; g < gap; g++) step(0, W_M2, 1);
    put(W_HD, gap);
    for (int b = 0; b < nb; b++) put(mk(2'b11, 128'(b + 1)), gap);
    put(W_TL, gap);
  endtask

  logic [15:0] bm;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #2;
    check("rst_valid", metadata_out_valid, 0);
    check("rst_ready", ready_out, 1);
    check("rst_hit", hit_cnt, 0);
    check("rst_flood", flood_cnt, 0);
    check("rst_err", err_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1;
    step(0, '0, 1);

    // learning then hit
    send_pkt(48'h00AA_BBCC_DDEE, 48'h0011_2233_4455, 4'd2, 2, 0, bm);
    check("A_bitmap", bm, 16'h00FB);
    check("A_flood", flood_cnt, 1);
    send_pkt(48'h0011_2233_4455, 48'h0000_0000_0B05, 4'd5, 1, 0, bm);
    check("B_bitmap", bm, 16'h0004);
    check("B_hit", hit_cnt, 1);

    // broadcast, smac learned
    send_pkt(48'hFFFF_FFFF_FFFF, 48'h0000_0000_00C0, 4'd0, 1, 0, bm);
    check("bcast_bitmap", bm, 16'h00FE);
    send_pkt(48'h0000_0000_00C0, 48'h0, 4'd3, 0, 1, bm);
    check("learned_bc_smac", bm, 16'h0001);
    check("hit2", hit_cnt, 2);

    // ingress out of range: flood all, no learning
    send_pkt(48'h00AB_0000_0001, 48'h0000_0000_00D0, 4'd9, 0, 0, bm);
    check("ing9_bitmap", bm, 16'h00FF);
    send_pkt(48'h0000_0000_00D0, 48'h0, 4'd1, 0, 2, bm);
    check("ing9_nolearn", bm, 16'h00FD);

    // malformed: M0 then tail
    wait_ready();
    step(1, W_M0, 1);
    check("mal_ready0", ready_out, 0);
    step(1, W_TL, 1);
    check("mal_data", metadata_out, W_TL);
    check("mal_err", err_cnt, 1);
    check("mal_ready1", ready_out, 1);
    send_pkt(48'h0011_2233_4455, 48'h0, 4'd6, 1, 0, bm);
    check("post_mal", bm, 16'h0004);

    // unexpected tag inside packet: skip to tail
    wait_ready();
    put(W_M0, 0);
    put(w_m1(48'h0000_0000_0B05, 48'h0, 4'd1), 0);
    put(W_M2, 0);
    put(W_HD, 0);
    put(mk(2'b00, 128'hBAD), 0);
    put(mk(2'b11, 128'h5), 0);
    put(mk(2'b01, 128'h6), 0);
    put(W_TL, 0);
    check("skip_err", err_cnt, 2);

    // backpressure in IDLE
    step(0, '0, 0);
    check("bp_ready0", ready_out, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, W_M0, 0);
      check("bp_noaccept", metadata_out_valid, 0);
    end
    step(0, '0, 1);
    check("bp_ready1", ready_out, 1);

    // async reset during PKT
    put(W_M0, 0);
    put(w_m1(48'h00AA_0000_0001, 48'h0000_0000_0E01, 4'd4), 0);
    put(W_M2, 0);
    put(W_HD, 0);
    put(mk(2'b11, 128'h1), 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("ar_valid", metadata_out_valid, 0);
    check("ar_data", metadata_out, 0);
    check("ar_ready", ready_out, 1);
    check("ar_hit", hit_cnt, 0);
    check("ar_flood", flood_cnt, 0);
    check("ar_err", err_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, mk(2'b11, 128'h2), 1);
    check("ar_body_drop", metadata_out_valid, 0);
    step(1, W_TL, 1);
    check("ar_tail_drop", metadata_out_valid, 0);
    send_pkt(48'h0011_2233_4455, 48'h0, 4'd3, 0, 0, bm);
    check("ar_tbl_clear", bm, 16'h00F7);

    // table wrap
    for (int i = 0; i < 17; i++)
      send_pkt(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0100 + 48'(i),
               4'(i % 8), 0, 0, bm);
    send_pkt(48'h0000_0000_0100, 48'h0, 4'd7, 0, 0, bm);
    check("wrap_evicted", bm, 16'h007F);
    send_pkt(48'h0000_0000_0101, 48'h0, 4'd7, 0, 0, bm);
    check("wrap_kept", bm, 16'h0002);
    send_pkt(48'h0000_0000_0110, 48'h0, 4'd7, 0, 0, bm);
    check("wrap_new0", bm, 16'h0001);
    check("wrap_flood", flood_cnt, 19);
    check("wrap_hit", hit_cnt, 2);

    step(0, '0, 1);
    step(0, '0, 1);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
